ip_cdc_event_sched: RTL and testbench
=====================================

IP_CDC_EVENT_SCHED -- requirements
Module: ip_cdc_event_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of clockA-domain event requesters, range 2..16.
REQ-002 Parameter IDX_W, default 2: width of channel index; SHALL equal clog2(NUM_REQ).
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth in each direction, range 2..3.
REQ-004 clockA  input  1  domain A clock.
REQ-005 resetA  input  1  domain A reset, asynchronous, active-low.
REQ-006 clockB  input  1  domain B clock.
REQ-007 resetB  input  1  domain B reset, asynchronous, active-low.
REQ-008 reqA  input  NUM_REQ  per-channel event pulse, clockA.
REQ-009 pendA  output  NUM_REQ  per-channel event latched, not yet granted.
REQ-010 doneA  output  NUM_REQ  one-cycle pulse when that channel's event completes the full handshake.
REQ-011 dropA  output  NUM_REQ  one-cycle pulse when reqA[i] arrives while pendA[i] is already 1.
REQ-012 busyA  output  1  transfer in flight.
REQ-013 evtB  output  1  one-cycle clockB pulse per delivered event.
REQ-014 evtIdxB  output  IDX_W  channel index of the event; valid when evtB=1, held until the next evtB.

Function
REQ-015 reqA[i]=1 SHALL set pendA[i] on the next clockA edge; pendA[i] SHALL clear in the cycle channel i is granted.
REQ-016 reqA[i]=1 with pendA[i]=1 and no grant of i in that cycle SHALL pulse dropA[i] and merge into the existing pending event.
REQ-017 reqA[i]=1 in the cycle i is granted SHALL re-set pendA[i], with no drop.
REQ-018 A-side FSM states: IDLE, HOLD, RELEASE.
REQ-019 IDLE: if any pendA bit is 1, grant one channel by round-robin, load idxA, go to HOLD; lockA=0.
REQ-020 Round-robin: highest priority goes to the channel after the last granted, wrapping NUM_REQ-1 -> 0; after reset, channel 0 has highest priority.
REQ-021 HOLD: lockA=1; wait for synchronized lockB=1, then go to RELEASE.
REQ-022 RELEASE: lockA=0; wait for synchronized lockB=0, then pulse doneA[idxA] and go to IDLE in the same cycle.
REQ-023 busyA SHALL be 1 in HOLD and RELEASE, 0 in IDLE.
REQ-024 idxA SHALL be registered at least one clockA cycle before lockA rises, and SHALL stay stable until RELEASE exits.
REQ-025 B side: lockB SHALL follow synchronized lockA.
REQ-026 On a lockB 0->1 transition, evtIdxB SHALL capture idxA directly (quasi-static) and evtB SHALL pulse on that same edge.
REQ-027 Exactly one evtB SHALL occur per grant; no duplicate or missing events for any clock ratio.
REQ-028 Latency from grant to evtB SHALL be SYNC_STAGES+1 clockB cycles, +/-1.
REQ-029 Minimum IDLE-to-IDLE turnaround is 2*(SYNC_STAGES+1) cycles of each domain.
REQ-030 Back-to-back pending events SHALL be granted in the IDLE cycle that follows doneA, with no extra bubble.

Reset
REQ-031 On resetA: FSM=IDLE, pendA=0, idxA=0, lockA=0, RR pointer=0, doneA=0, dropA=0, busyA=0; A-side sync flops cleared.
REQ-032 On resetB: lockB=0, evtB=0, evtIdxB=0; B-side sync flops cleared.
REQ-033 resetA asserted mid-transfer: the in-flight and pending events are lost, with no doneA; B sees lockA fall and returns lockB to 0 without a further evtB.
REQ-034 resetB asserted mid-transfer while A is in HOLD: A SHALL stay in HOLD until B exits reset and completes the handshake, producing exactly one evtB.
REQ-035 Reset deassertion SHALL be synchronized externally per domain; this block does not re-synchronize reset.

Structure
REQ-036 Shared package ip_cdc_pkg SHALL hold the A-FSM state enum (IDLE/HOLD/RELEASE) and default SYNC_STAGES.
REQ-037 Round-robin grant logic SHALL be a separate sub-module ip_rr_arbiter, with inputs req/advance and outputs one-hot grant plus index.
REQ-038 Synchronizers SHALL be plain flop chains with no combinational logic between stages; lockA and lockB SHALL be driven directly from flops.

Verification
REQ-039 Single event: NUM_REQ=4, clockA 100 MHz, clockB 33 MHz, reqA=4'b0100 for one cycle -> one evtB with evtIdxB=2, then doneA=4'b0100, then busyA=0.
REQ-040 Round-robin: reqA=4'b1111 for one cycle -> evtIdxB sequence 0,1,2,3; a repeat of 4'b1111 after that SHALL give 0,1,2,3 again.
REQ-041 Merge: reqA[1] pulsed 3 times while channel 0 is in flight -> dropA[1] pulses twice and exactly one evtB with idx=1.
REQ-042 Ratio sweep: clockB at 10x, 1x and 0.1x clockA with 1000 random events -> count of evtB equals count of doneA equals grants, and each index matches the grant order.
REQ-043 Reset mid-operation: resetA asserted in HOLD -> no doneA and at most one evtB; resetB asserted in HOLD -> exactly one evtB after release and doneA follows.

Source files
------------

// File: rtl/ip_cdc_pkg.sv
// Shared definitions for the clock-domain-crossing event scheduler.
//   a_state_e     : A-side handshake FSM states
//   DefSyncStages : default synchronizer depth in each direction
package ip_cdc_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StHold    = 2'd1,
      StRelease = 2'd2
   } a_state_e;

   localparam int unsigned DefSyncStages = 2;

endpackage

// File: rtl/ip_cdc_event_sched_if.sv
// Event bus of ip_cdc_event_sched.
//   reqA    : per-channel event pulse (clockA)
//   pendA   : per-channel event latched, not yet granted (clockA)
//   doneA   : one-cycle pulse when a channel's handshake completes (clockA)
//   dropA   : one-cycle pulse when a request merges into a pending one (clockA)
//   busyA   : transfer in flight (clockA)
//   evtB    : one-cycle pulse per delivered event (clockB)
//   evtIdxB : channel index of the last delivered event (clockB)
// master = requester side, slave = scheduler side.
interface ip_cdc_event_sched_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
);

   logic [NUM_REQ-1:0] reqA;
   logic [NUM_REQ-1:0] pendA;
   logic [NUM_REQ-1:0] doneA;
   logic [NUM_REQ-1:0] dropA;
   logic               busyA;
   logic               evtB;
   logic [IDX_W-1:0]   evtIdxB;

   modport master (
      output reqA,
      input  pendA, doneA, dropA, busyA, evtB, evtIdxB
   );

   modport slave (
      input  reqA,
      output pendA, doneA, dropA, busyA, evtB, evtIdxB
   );

endinterface

// File: rtl/ip_rr_arbiter.sv
// Round-robin arbiter for the clockA domain.
//   clockA, resetA : clock and asynchronous active-low reset
//   req            : request vector
//   advance        : the current grant is accepted; rotate priority past it
//   grant          : one-hot grant (all zero when req is zero)
//   idx            : index of the granted channel
// Highest priority is the channel after the last accepted grant; channel 0 after reset.
module ip_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic               clockA,
   input  logic               resetA,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] scan;
   logic             found;

   // Walk the channels starting at the priority pointer, wrapping at NUM_REQ-1.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      scan  = ptr_q;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (!found && req[scan]) begin
            found       = 1'b1;
            grant[scan] = 1'b1;
            idx         = scan;
         end
         scan = (scan == IDX_W'(NUM_REQ - 1)) ? '0 : scan + IDX_W'(1);
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         ptr_d = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clockA or negedge resetA) begin
      if (!resetA) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ip_cdc_event_sched.sv
// Schedules per-channel clockA events onto a single clockB event stream using a
// four-phase lock handshake with a quasi-static channel index.
//   clockA, resetA : domain A clock, asynchronous active-low reset
//   clockB, resetB : domain B clock, asynchronous active-low reset
//   bus            : event bus (slave side), see ip_cdc_event_sched_if
// Parameters: NUM_REQ channels (2..16), IDX_W = clog2(NUM_REQ), SYNC_STAGES (2..3).
module ip_cdc_event_sched
   import ip_cdc_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned IDX_W       = 2,
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input logic                 clockA,
   input logic                 resetA,
   input logic                 clockB,
   input logic                 resetB,
   ip_cdc_event_sched_if.slave bus
);

   // ---------------- domain A ----------------
   a_state_e               state_q, state_d;
   logic [NUM_REQ-1:0]     pend_q, pend_d;
   logic [NUM_REQ-1:0]     arb_grant, grant_vec, done;
   logic [IDX_W-1:0]       arb_idx, idx_q, idx_d;
   logic                   advance;
   logic                   lock_a_q;
   logic [SYNC_STAGES-1:0] lockb_sync_q;
   logic                   lockb_s;

   // ---------------- domain B ----------------
   logic [SYNC_STAGES-1:0] locka_sync_q;
   logic                   locka_s;
   logic                   lock_b_q;
   logic                   evt_q;
   logic [IDX_W-1:0]       evt_idx_q;

   ip_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .clockA  (clockA),
      .resetA  (resetA),
      .req     (pend_q),
      .advance (advance),
      .grant   (arb_grant),
      .idx     (arb_idx)
   );

   assign lockb_s = lockb_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      advance = 1'b0;
      done    = '0;
      unique case (state_q)
         StIdle: begin
            if (|pend_q) begin
               advance = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            if (lockb_s) begin
               state_d = StRelease;
            end
         end
         StRelease: begin
            if (!lockb_s) begin
               done[idx_q] = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign grant_vec = advance ? arb_grant : '0;
   assign idx_d     = advance ? arb_idx : idx_q;
   // A request in its own grant cycle re-arms the channel instead of merging.
   assign pend_d    = (pend_q & ~grant_vec) | bus.reqA;

   always_ff @(posedge clockA or negedge resetA) begin
      if (!resetA) begin
         state_q      <= StIdle;
         pend_q       <= '0;
         idx_q        <= '0;
         lock_a_q     <= 1'b0;
         lockb_sync_q <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         idx_q        <= idx_d;
         // Lags the state by one cycle so idx_q is settled a full cycle before
         // lockA rises; B samples idx_q without synchronizing it.
         lock_a_q     <= (state_q == StHold);
         lockb_sync_q <= {lockb_sync_q[SYNC_STAGES-2:0], lock_b_q};
      end
   end

   assign locka_s = locka_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clockB or negedge resetB) begin
      if (!resetB) begin
         locka_sync_q <= '0;
         lock_b_q     <= 1'b0;
         evt_q        <= 1'b0;
         evt_idx_q    <= '0;
      end else begin
         locka_sync_q <= {locka_sync_q[SYNC_STAGES-2:0], lock_a_q};
         lock_b_q     <= locka_s;
         evt_q        <= locka_s & ~lock_b_q;
         if (locka_s && !lock_b_q) begin
            evt_idx_q <= idx_q;
         end
      end
   end

   assign bus.pendA   = pend_q;
   assign bus.doneA   = done;
   assign bus.dropA   = bus.reqA & pend_q & ~grant_vec;
   assign bus.busyA   = (state_q != StIdle);
   assign bus.evtB    = evt_q;
   assign bus.evtIdxB = evt_idx_q;

endmodule

// File: tb/tb_ip_cdc_event_sched.sv
// Bench for ip_cdc_event_sched: reset checks, a table of request patterns with
// expected event orders, hand sequences for merge/re-arm/reset corner cases and
// a randomized clock-ratio sweep scored against a channel-level reference model.
module tb_ip_cdc_event_sched;

   localparam int unsigned NUM_REQ     = 4;
   localparam int unsigned IDX_W       = 2;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int          NREQ        = 4;

   logic clockA, resetA, clockB, resetB;
   int   half_b = 150;
   int   total  = 0;
   int   bad    = 0;

   ip_cdc_event_sched_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

   ip_cdc_event_sched #(
      .NUM_REQ     (NUM_REQ),
      .IDX_W       (IDX_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clockA (clockA),
      .resetA (resetA),
      .clockB (clockB),
      .resetB (resetB),
      .bus    (bus)
   );

   initial begin
      clockA = 1'b0;
      forever #50 clockA = ~clockA;
   end

   initial begin
      clockB = 1'b0;
      forever #(half_b) clockB = ~clockB;
   end

   // Reference model state: pending set, priority pointer, expected streams.
   logic       mon_on = 1'b0;
   logic [3:0] pend_m = '0;
   int         ptr_m  = 0;
   int         exp_evt_q[$];
   int         exp_done_q[$];
   int         obs_q[$];
   int         n_grant = 0, n_evt = 0, n_done = 0, drop_cnt = 0, drop1_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] p, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int c = (ptr + k) % NREQ;
         if (p[c]) return c;
      end
      return -1;
   endfunction

   // A side: a channel is granted whenever the scheduler is idle and something
   // is pending; the choice is the first pending channel after the last grant.
   always @(negedge clockA) begin
      logic [3:0] gvec;
      int         g;
      if (resetA) begin
         if (bus.dropA[1]) drop1_cnt++;
         if (bus.dropA != '0) drop_cnt++;
         if (mon_on) begin
            if (bus.doneA != '0) begin
               n_done++;
               if (exp_done_q.size() == 0) check("doneA_has_grant", exp_done_q.size(), 1);
               else begin
                  g = exp_done_q.pop_front();
                  check("doneA_model", bus.doneA, 32'(1) << g);
               end
            end
            check("pendA_model", bus.pendA, pend_m);
            gvec = '0;
            if (!bus.busyA && pend_m != '0) begin
               g       = rr_pick(pend_m, ptr_m);
               gvec[g] = 1'b1;
               exp_evt_q.push_back(g);
               exp_done_q.push_back(g);
               ptr_m = (g + 1) % NREQ;
               n_grant++;
            end
            check("dropA_model", bus.dropA, bus.reqA & pend_m & ~gvec);
            pend_m = (pend_m & ~gvec) | bus.reqA;
         end
      end
   end

   always @(negedge clockB) begin
      if (resetB && bus.evtB) begin
         n_evt++;
         obs_q.push_back(int'(bus.evtIdxB));
         if (mon_on) begin
            if (exp_evt_q.size() == 0) check("evtB_has_grant", exp_evt_q.size(), 1);
            else check("evtIdxB_model", bus.evtIdxB, exp_evt_q.pop_front());
         end
      end
   end

   task automatic pulse_req(input logic [3:0] v);
      @(posedge clockA); #1 bus.reqA = v;
      @(posedge clockA); #1 bus.reqA = '0;
   endtask

   task automatic wait_busy(input string name);
      int c = 0;
      @(negedge clockA);
      while (bus.busyA !== 1'b1 && c < 2000) begin
         @(negedge clockA);
         c++;
      end
      check(name, bus.busyA, 1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c = 0;
      @(negedge clockA);
      while (!(bus.busyA === 1'b0 && bus.pendA === '0) && c < budget) begin
         @(negedge clockA);
         c++;
      end
      check(name, {bus.busyA, bus.pendA}, 0);
   endtask

   typedef struct {
      logic [3:0] req;
      int         n;
      logic [7:0] seq;  // event i index at bits [2i+1:2i]
   } vec_t;

   vec_t tbl[7];

   initial begin
      #60000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, d1, e0, g0, dn0, dn, c;
      int halves[3];
      int counts[3];

      tbl[0] = '{4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
      tbl[1] = '{4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
      tbl[2] = '{4'b0100, 1, {2'd0, 2'd0, 2'd0, 2'd2}};
      tbl[3] = '{4'b0011, 2, {2'd0, 2'd0, 2'd1, 2'd0}};
      tbl[4] = '{4'b1010, 2, {2'd0, 2'd0, 2'd1, 2'd3}};
      tbl[5] = '{4'b1001, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
      tbl[6] = '{4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}};
      halves = '{5, 53, 503};
      counts = '{200, 200, 120};

      bus.reqA = '0;
      resetA   = 1'b0;
      resetB   = 1'b0;
      repeat (3) @(negedge clockA);
      check("rst_pendA", bus.pendA, 0);
      check("rst_doneA", bus.doneA, 0);
      check("rst_dropA", bus.dropA, 0);
      check("rst_busyA", bus.busyA, 0);
      check("rst_evtB", bus.evtB, 0);
      check("rst_evtIdxB", bus.evtIdxB, 0);
      resetA = 1'b1;
      resetB = 1'b1;
      @(posedge clockA);
      mon_on = 1'b1;

      // Table: one-cycle request patterns and the event order they must produce.
      for (int r = 0; r < 7; r++) begin
         obs_q.delete();
         d0 = drop_cnt;
         pulse_req(tbl[r].req);
         wait_idle($sformatf("row%0d_idle", r), 3000);
         check($sformatf("row%0d_evt_count", r), obs_q.size(), tbl[r].n);
         for (int i = 0; i < tbl[r].n; i++) begin
            if (i < obs_q.size())
               check($sformatf("row%0d_idx%0d", r, i), obs_q[i], tbl[r].seq[2*i +: 2]);
         end
         check($sformatf("row%0d_idx_held", r), bus.evtIdxB, tbl[r].seq[2*(tbl[r].n-1) +: 2]);
         check($sformatf("row%0d_drops", r), drop_cnt - d0, 0);
      end

      // Merge: channel 1 requested three times while channel 0 is in flight.
      obs_q.delete();
      d1 = drop1_cnt;
      pulse_req(4'b0001);
      wait_busy("merge_busy");
      repeat (3) begin
         @(posedge clockA); #1 bus.reqA = 4'b0010;
         @(posedge clockA); #1 bus.reqA = '0;
      end
      c = 0;
      @(negedge clockA);
      while (bus.doneA === '0 && c < 3000) begin
         @(negedge clockA);
         c++;
      end
      check("merge_done0", bus.doneA, 4'b0001);
      @(negedge clockA);
      check("b2b_idle_gap", {bus.busyA, bus.pendA}, 5'b0_0010);
      @(negedge clockA);
      check("b2b_granted", {bus.busyA, bus.pendA}, 5'b1_0000);
      wait_idle("merge_idle", 3000);
      check("merge_drops", drop1_cnt - d1, 2);
      check("merge_evt_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         check("merge_idx0", obs_q[0], 0);
         check("merge_idx1", obs_q[1], 1);
      end

      // resetB while A holds the lock: one event after B comes back.
      obs_q.delete();
      e0 = n_evt;
      pulse_req(4'b1000);
      wait_busy("rstb_busy");
      resetB = 1'b0;
      #1;
      check("rstb_idx_cleared", bus.evtIdxB, 0);
      #3000;
      @(negedge clockA);
      check("rstb_hold_busy", bus.busyA, 1);
      check("rstb_no_evt_in_reset", n_evt - e0, 0);
      resetB = 1'b1;
      wait_idle("rstb_idle", 3000);
      check("rstb_one_evt", obs_q.size(), 1);
      if (obs_q.size() == 1) check("rstb_idx", obs_q[0], 3);

      // Request held into its own grant cycle re-arms without a drop.
      obs_q.delete();
      d0 = drop_cnt;
      @(posedge clockA); #1 bus.reqA = 4'b0001;
      @(posedge clockA); #1;
      @(posedge clockA); #1 bus.reqA = '0;
      @(negedge clockA);
      check("rearm_pend", {bus.busyA, bus.pendA}, 5'b1_0001);
      wait_idle("rearm_idle", 3000);
      check("rearm_drops", drop_cnt - d0, 0);
      check("rearm_evt_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         check("rearm_idx0", obs_q[0], 0);
         check("rearm_idx1", obs_q[1], 0);
      end

      // Random sweep with clockB at ~10x, ~1x and ~0.1x clockA.
      for (int r = 0; r < 3; r++) begin
         half_b = halves[r];
         g0  = n_grant;
         e0  = n_evt;
         dn0 = n_done;
         c   = 0;
         while (n_grant - g0 < counts[r] && c < 20000) begin
            @(posedge clockA); #1;
            if ($urandom_range(0, 3) == 0) bus.reqA = 4'($urandom_range(1, 15));
            else bus.reqA = '0;
            c++;
         end
         @(posedge clockA); #1 bus.reqA = '0;
         wait_idle($sformatf("sweep%0d_idle", r), 20000);
         check($sformatf("sweep%0d_grants", r), (n_grant - g0) >= counts[r], 1);
         check($sformatf("sweep%0d_evt_eq_grant", r), n_evt - e0, n_grant - g0);
         check($sformatf("sweep%0d_done_eq_grant", r), n_done - dn0, n_grant - g0);
         check($sformatf("sweep%0d_queues_empty", r), exp_evt_q.size() + exp_done_q.size(), 0);
      end
      half_b = 150;
      repeat (20) @(negedge clockA);

      // resetA while holding: in-flight and pending events vanish without doneA.
      mon_on = 1'b0;
      pulse_req(4'b0010);
      wait_busy("rsta_busy");
      @(posedge clockA); #1 bus.reqA = 4'b0100;
      @(posedge clockA); #1 bus.reqA = '0;
      e0 = n_evt;
      @(negedge clockA);
      resetA = 1'b0;
      #1;
      check("rsta_pendA", bus.pendA, 0);
      check("rsta_busyA", bus.busyA, 0);
      check("rsta_doneA", bus.doneA, 0);
      repeat (3) @(negedge clockA);
      resetA = 1'b1;
      dn = 0;
      repeat (300) begin
         @(negedge clockA);
         if (bus.doneA != '0) dn++;
      end
      check("rsta_no_done", dn, 0);
      check("rsta_evt_le1", (n_evt - e0) <= 1, 1);
      check("rsta_idle", {bus.busyA, bus.pendA}, 0);

      // After resetA the priority pointer restarts at channel 0.
      pend_m = '0;
      ptr_m  = 0;
      exp_evt_q.delete();
      exp_done_q.delete();
      obs_q.delete();
      @(posedge clockA);
      mon_on = 1'b1;
      pulse_req(4'b1001);
      wait_idle("post_rsta_idle", 3000);
      check("post_rsta_evt_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         check("post_rsta_idx0", obs_q[0], 0);
         check("post_rsta_idx1", obs_q[1], 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
